// File: rtl/sha_word_mem_responder.sv
// Word-addressed single-port RAM shared between the SHA-256 core port and a host port, selected by core_own.
// Tracks core write-back of h0..h7 at out_base; reads return after READ_LATENCY edges through a tagged pipeline.
module sha_word_mem_responder #(
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        core_own,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_rvalid,
  input  logic [15:0] out_base,
  input  logic        clear_status,
  output logic [7:0]  hash_mask,
  output logic        hash_ready,
  output logic [7:0]  wr_count,
  output logic        addr_err
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);
  localparam int          PD      = READ_LATENCY - 1;

  logic [31:0] mem_array [DEPTH];

  logic [15:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_in_range, acc_active, acc_we, wr_en;
  logic        rd_core_vld, rd_host_vld;
  logic [31:0] rd_dat;
  logic        core_wr, hash_hit;
  logic [15:0] hash_off;

  logic [31:0] tail_dat;
  logic        tail_cv, tail_hv;

  logic [31:0] mem_read_data_q, mem_read_data_d;
  logic [31:0] host_rdata_q, host_rdata_d;
  logic        host_rvalid_q, host_rvalid_d;
  logic [7:0]  hash_mask_q, hash_mask_d;
  logic        hash_ready_q, hash_ready_d;
  logic [7:0]  wr_count_q, wr_count_d;
  logic        addr_err_q, addr_err_d;

  // Only the owning side is looked at; the other port's inputs are don't-care.
  always_comb begin
    acc_addr     = core_own ? mem_addr : host_addr;
    acc_wdata    = core_own ? mem_write_data : host_wdata;
    acc_we       = core_own ? mem_we : host_we;
    acc_active   = core_own | host_req;
    acc_in_range = ({1'b0, acc_addr} < DEPTH_W);
    wr_en        = acc_active & acc_we & acc_in_range;
    rd_core_vld  = core_own;
    rd_host_vld  = ~core_own & host_req & ~host_we;
    if (!acc_in_range)
      rd_dat = 32'h0;
    else if (core_own && mem_we)
      rd_dat = mem_write_data;
    else
      rd_dat = mem_array[acc_addr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem_array[acc_addr[AW-1:0]] <= acc_wdata;
  end

  generate
    if (PD == 0) begin : g_direct
      assign tail_dat = rd_dat;
      assign tail_cv  = rd_core_vld;
      assign tail_hv  = rd_host_vld;
    end else begin : g_pipe
      logic [31:0]   pdat_q [PD];
      logic [31:0]   pdat_d [PD];
      logic [PD-1:0] pcv_q, pcv_d, phv_q, phv_d;

      always_comb begin
        pdat_d[0] = rd_dat;
        pcv_d[0]  = rd_core_vld;
        phv_d[0]  = rd_host_vld;
        for (int i = 1; i < PD; i++) begin
          pdat_d[i] = pdat_q[i-1];
          pcv_d[i]  = pcv_q[i-1];
          phv_d[i]  = phv_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < PD; i++) pdat_q[i] <= 32'h0;
          pcv_q <= '0;
          phv_q <= '0;
        end else begin
          for (int i = 0; i < PD; i++) pdat_q[i] <= pdat_d[i];
          pcv_q <= pcv_d;
          phv_q <= phv_d;
        end
      end

      assign tail_dat = pdat_q[PD-1];
      assign tail_cv  = pcv_q[PD-1];
      assign tail_hv  = phv_q[PD-1];
    end
  endgenerate

  // Clear acts first so a write in the same cycle lands on a cleared status.
  always_comb begin
    core_wr  = core_own & mem_we;
    hash_off = mem_addr - out_base;
    hash_hit = core_wr & acc_in_range & (mem_addr >= out_base) & (hash_off < 16'd8);

    hash_mask_d = clear_status ? 8'h00 : hash_mask_q;
    if (hash_hit)
      hash_mask_d[hash_off[2:0]] = 1'b1;
    hash_ready_d = &hash_mask_d;

    wr_count_d = clear_status ? 8'h00 : wr_count_q;
    if (core_wr && (wr_count_d != 8'hFF))
      wr_count_d = wr_count_d + 8'd1;

    addr_err_d = clear_status ? 1'b0 : addr_err_q;
    if (acc_active && !acc_in_range)
      addr_err_d = 1'b1;

    mem_read_data_d = tail_cv ? tail_dat : mem_read_data_q;
    host_rdata_d    = tail_hv ? tail_dat : host_rdata_q;
    host_rvalid_d   = tail_hv;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_data_q <= 32'h0;
      host_rdata_q    <= 32'h0;
      host_rvalid_q   <= 1'b0;
      hash_mask_q     <= 8'h00;
      hash_ready_q    <= 1'b0;
      wr_count_q      <= 8'h00;
      addr_err_q      <= 1'b0;
    end else begin
      mem_read_data_q <= mem_read_data_d;
      host_rdata_q    <= host_rdata_d;
      host_rvalid_q   <= host_rvalid_d;
      hash_mask_q     <= hash_mask_d;
      hash_ready_q    <= hash_ready_d;
      wr_count_q      <= wr_count_d;
      addr_err_q      <= addr_err_d;
    end
  end

  assign mem_read_data = mem_read_data_q;
  assign host_rdata    = host_rdata_q;
  assign host_rvalid   = host_rvalid_q;
  assign hash_mask     = hash_mask_q;
  assign hash_ready    = hash_ready_q;
  assign wr_count      = wr_count_q;
  assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_sha_word_mem_responder.sv
// Bench for sha_word_mem_responder: two instances (READ_LATENCY 1 and 3) share stimulus;
// a vector table covers single-cycle behaviour, hand sequences cover latency and reset.
module tb_sha_word_mem_responder;

  logic        clk, reset_n, core_own, mem_we, host_req, host_we, clear_status;
  logic [15:0] mem_addr, host_addr, out_base;
  logic [31:0] mem_write_data, host_wdata;

  logic [31:0] mrd1, hrd1, mrd3, hrd3;
  logic        hrv1, rdy1, err1, hrv3, rdy3, err3;
  logic [7:0]  mask1, cnt1, mask3, cnt3;

  int n_chk = 0;
  int n_pass = 0;

  sha_word_mem_responder #(.DEPTH(256), .READ_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .core_own(core_own), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mrd1), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(hrd1), .host_rvalid(hrv1),
    .out_base(out_base), .clear_status(clear_status), .hash_mask(mask1), .hash_ready(rdy1),
    .wr_count(cnt1), .addr_err(err1));

  sha_word_mem_responder #(.DEPTH(256), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .core_own(core_own), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mrd3), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(hrd3), .host_rvalid(hrv3),
    .out_base(out_base), .clear_status(clear_status), .hash_mask(mask3), .hash_ready(rdy3),
    .wr_count(cnt3), .addr_err(err3));

  always #5 clk = ~clk;

  typedef struct {
    logic        own, we;
    logic [15:0] addr;
    logic [31:0] wd;
    logic        hreq, hwe;
    logic [15:0] haddr;
    logic [31:0] hwd;
    logic        clr;
    logic [31:0] mrd;
    logic        hrv;
    logic [31:0] hrd;
    logic [7:0]  mask;
    logic        rdy;
    logic [7:0]  cnt;
    logic        err;
  } vec_t;

  vec_t vq[$];

  function automatic logic [31:0] word(int i);
    return (i == 0) ? 32'h61626380 : {16'hB00C, 8'h00, 8'(i)};
  endfunction

  function automatic logic [31:0] hw(int k);
    return {16'hC0DE, 8'h00, 8'(k)};
  endfunction

  function automatic vec_t mk(logic own, logic we, logic [15:0] addr, logic [31:0] wd, logic hreq,
                              logic hwe, logic [15:0] haddr, logic [31:0] hwd, logic clr,
                              logic [31:0] mrd, logic hrv, logic [31:0] hrd, logic [7:0] mask,
                              logic rdy, logic [7:0] cnt, logic err);
    vec_t v;
    v.own = own; v.we = we; v.addr = addr; v.wd = wd; v.hreq = hreq; v.hwe = hwe;
    v.haddr = haddr; v.hwd = hwd; v.clr = clr; v.mrd = mrd; v.hrv = hrv; v.hrd = hrd;
    v.mask = mask; v.rdy = rdy; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Called at a negedge: apply inputs, let one posedge pass, return at the next negedge.
  task automatic drive(input logic own, input logic we, input logic [15:0] addr, input logic [31:0] wd,
                       input logic hreq, input logic hwe, input logic [15:0] haddr,
                       input logic [31:0] hwd, input logic clr);
    core_own = own; mem_we = we; mem_addr = addr; mem_write_data = wd;
    host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd; clear_status = clr;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " mrd1"}, mrd1, 32'h0);   chk({tag, " hrd1"}, hrd1, 32'h0);
    chk({tag, " hrv1"}, hrv1, 1'b0);    chk({tag, " mask1"}, mask1, 8'h00);
    chk({tag, " rdy1"}, rdy1, 1'b0);    chk({tag, " cnt1"}, cnt1, 8'h00);
    chk({tag, " err1"}, err1, 1'b0);    chk({tag, " mrd3"}, mrd3, 32'h0);
    chk({tag, " hrv3"}, hrv3, 1'b0);    chk({tag, " cnt3"}, cnt3, 8'h00);
  endtask

  initial begin
    logic [7:0] mstep [8];
    logic       exp_hrv3 [6];
    int         hr_addr [6];
    vec_t       v;

    mstep = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    clk = 1'b0; reset_n = 1'b0; out_base = 16'd16;
    core_own = 1'b0; mem_we = 1'b0; mem_addr = 16'h0; mem_write_data = 32'h0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0; host_wdata = 32'h0; clear_status = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 24; i++) drive(0, 0, 0, 0, 1, 1, 16'(i), word(i), 0);

    // own we addr wd | hreq hwe haddr hwd | clr || mrd hrv hrd mask rdy cnt err
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, word(0), 8'h00, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, word(0), 8'h00, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 5, 0, 0, 0, 1, word(5), 8'h00, 0, 0, 0));
    vq.push_back(mk(1, 0, 5, 0, 1, 1, 5, 32'hDEADBEEF, 0, word(5), 0, word(5), 8'h00, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 5, 0, 0, word(5), 1, word(5), 8'h00, 0, 0, 0));
    vq.push_back(mk(0, 1, 16, 32'hFFFFFFFF, 0, 0, 0, 0, 0, word(5), 0, word(5), 8'h00, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      vq.push_back(mk(1, 1, 16'(16 + k), hw(k), 0, 0, 0, 0, 0, hw(k), 0, word(5), mstep[k],
                      (k == 7), 8'(k + 1), 0));
    vq.push_back(mk(1, 1, 18, hw(2), 0, 0, 0, 0, 1, hw(2), 0, word(5), 8'h04, 0, 1, 0));
    vq.push_back(mk(1, 0, 16'h0100, 0, 0, 0, 0, 0, 0, 0, 0, word(5), 8'h04, 0, 1, 1));
    vq.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0, 0, word(3), 0, word(5), 8'h04, 0, 1, 1));
    vq.push_back(mk(1, 0, 2, 0, 0, 0, 0, 0, 1, word(2), 0, word(5), 8'h00, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 16'h0200, 0, 0, word(2), 1, 0, 8'h00, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, word(2), 0, 0, 8'h00, 0, 0, 0));
    vq.push_back(mk(1, 1, 16'h0107, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 1));
    vq.push_back(mk(1, 1, 15, word(15), 0, 0, 0, 0, 0, word(15), 0, 0, 8'h00, 0, 2, 1));

    foreach (vq[i]) begin
      v = vq[i];
      drive(v.own, v.we, v.addr, v.wd, v.hreq, v.hwe, v.haddr, v.hwd, v.clr);
      chk($sformatf("v%0d mrd", i), mrd1, v.mrd);
      chk($sformatf("v%0d hrv", i), hrv1, v.hrv);
      chk($sformatf("v%0d hrd", i), hrd1, v.hrd);
      chk($sformatf("v%0d mask", i), mask1, v.mask);
      chk($sformatf("v%0d rdy", i), rdy1, v.rdy);
      chk($sformatf("v%0d cnt", i), cnt1, v.cnt);
      chk($sformatf("v%0d err", i), err1, v.err);
      chk($sformatf("v%0d mask3", i), mask3, v.mask);
      chk($sformatf("v%0d cnt3", i), cnt3, v.cnt);
      chk($sformatf("v%0d err3", i), err3, v.err);
    end

    // Core streams 0..15; latency-3 data lags by two further edges.
    for (int k = 0; k < 18; k++) begin
      drive(1, 0, 16'((k < 16) ? k : 15), 0, 0, 0, 0, 0, 0);
      if (k < 16) chk($sformatf("stream1 k%0d", k), mrd1, word(k));
      if (k == 0) chk("stream3 before", mrd3, 32'h0);
      if (k == 1) chk("stream3 prior wr", mrd3, word(15));
      if (k >= 2) chk($sformatf("stream3 k%0d", k), mrd3, word(k - 2));
    end

    // Host reads at latency 3, including one that completes after ownership flips.
    hr_addr  = '{0, -1, 1, 2, -1, -1};
    exp_hrv3 = '{0, 0, 1, 0, 1, 1};
    for (int k = 0; k < 6; k++) begin
      if (hr_addr[k] >= 0) drive(0, 0, 0, 0, 1, 0, 16'(hr_addr[k]), 0, 0);
      else drive(k == 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("hrv3 k%0d", k), hrv3, exp_hrv3[k]);
    end
    chk("hrd3 last", hrd3, word(2));

    // Reset during an in-flight latency-3 host read.
    drive(1, 1, 16, hw(0), 0, 0, 0, 0, 0);
    drive(1, 0, 16'h0100, 0, 0, 0, 0, 0, 0);
    chk("pre-reset cnt", cnt3, 8'd3);
    chk("pre-reset err", err3, 1'b1);
    core_own = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0; mem_we = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("async");
    host_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("lost rvalid k%0d", k), hrv3, 1'b0);
    end
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("retained hrv1", hrv1, 1'b1);
    chk("retained hrd1", hrd1, word(0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("retained hrv3", hrv3, 1'b1);
    chk("retained hrd3", hrd3, word(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
